// File: rtl/game_cmd_scheduler_pkg.sv
// Shared command/phase encodings and pending-flag helpers for the game command scheduler.
package game_cmd_scheduler_pkg;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_START  = 3'd1,
        CMD_ROTATE = 3'd2,
        CMD_LEFT   = 3'd3,
        CMD_RIGHT  = 3'd4,
        CMD_DROP   = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_PLAY = 2'd1,
        PH_OVER = 2'd2
    } phase_e;

    // Field order is issue priority, highest first.
    typedef struct packed {
        logic start;
        logic rotate;
        logic left;
        logic right;
        logic drop;
    } pend_t;

    function automatic pend_t phase_mask(phase_e ph);
        pend_t m;
        m = '0;
        if (ph == PH_PLAY) begin
            m        = '1;
            m.start  = 1'b0;
        end else begin
            m.start  = 1'b1;
        end
        return m;
    endfunction

    function automatic cmd_e pick_cmd(pend_t p);
        cmd_e c;
        if (p.start)       c = CMD_START;
        else if (p.rotate) c = CMD_ROTATE;
        else if (p.left)   c = CMD_LEFT;
        else if (p.right)  c = CMD_RIGHT;
        else if (p.drop)   c = CMD_DROP;
        else               c = CMD_NONE;
        return c;
    endfunction

    function automatic pend_t cmd_to_pend(cmd_e c);
        pend_t p;
        p = '0;
        case (c)
            CMD_START:  p.start  = 1'b1;
            CMD_ROTATE: p.rotate = 1'b1;
            CMD_LEFT:   p.left   = 1'b1;
            CMD_RIGHT:  p.right  = 1'b1;
            CMD_DROP:   p.drop   = 1'b1;
            default:    ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/game_cmd_scheduler_key_repeat.sv
// Press-edge detector with hold-to-repeat: strobes set_o on the press, after repeat_delay_p
// ticks of holding, and every repeat_rate_p ticks after that.
module game_cmd_scheduler_key_repeat
    import game_cmd_scheduler_pkg::*;
#(
    parameter int repeat_delay_p = 16,
    parameter int repeat_rate_p  = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic tick_i,
    input  logic key_i,
    output logic set_o
);
    localparam int max_lp = (repeat_delay_p > repeat_rate_p) ? repeat_delay_p : repeat_rate_p;
    localparam int cnt_w_lp = $clog2(max_lp) + 1;
    localparam logic [cnt_w_lp-1:0] delay_last_lp = cnt_w_lp'(repeat_delay_p - 1);
    localparam logic [cnt_w_lp-1:0] rate_last_lp  = cnt_w_lp'(repeat_rate_p - 1);
    localparam logic [cnt_w_lp-1:0] one_lp        = cnt_w_lp'(1);

    logic                held_q;
    logic                repeating_q;
    logic [cnt_w_lp-1:0] cnt_q;
    logic                press;
    logic                terminal;

    assign press    = key_i && !held_q;
    assign terminal = repeating_q ? (cnt_q == rate_last_lp) : (cnt_q == delay_last_lp);
    assign set_o    = press || (key_i && tick_i && terminal);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            held_q      <= 1'b0;
            repeating_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            held_q <= key_i;
            if (!key_i) begin
                repeating_q <= 1'b0;
                cnt_q       <= '0;
            end else if (tick_i) begin
                if (terminal) begin
                    repeating_q <= 1'b1;
                    cnt_q       <= '0;
                end else begin
                    cnt_q <= cnt_q + one_lp;
                end
            end
        end
    end

endmodule

// File: rtl/game_cmd_scheduler.sv
// Serialises key requests and the gravity timer into one valid/ready command stream and
// sequences the IDLE/PLAY/OVER game phase.
module game_cmd_scheduler
    import game_cmd_scheduler_pkg::*;
#(
    parameter int repeat_delay_p = 16,
    parameter int repeat_rate_p  = 4,
    parameter int drop_period_p  = 32,
    parameter int level_w_p      = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 tick_64hz_i,
    input  logic [3:0]           keys_i,
    input  logic [level_w_p-1:0] level_i,
    input  logic                 lose_i,
    output logic [2:0]           cmd_o,
    output logic                 cmd_v_o,
    input  logic                 cmd_ready_i,
    output logic [1:0]           phase_o
);
    localparam int drop_w_lp = $clog2(drop_period_p) + 1;
    localparam logic [drop_w_lp-1:0] drop_one_lp = drop_w_lp'(1);

    logic key_left, key_right, key_rotate, key_start;
    assign {key_left, key_right, key_rotate, key_start} = keys_i;

    logic set_left, set_right;

    game_cmd_scheduler_key_repeat #(
        .repeat_delay_p (repeat_delay_p),
        .repeat_rate_p  (repeat_rate_p)
    ) u_key_repeat_left (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .tick_i  (tick_64hz_i),
        .key_i   (key_left),
        .set_o   (set_left)
    );

    game_cmd_scheduler_key_repeat #(
        .repeat_delay_p (repeat_delay_p),
        .repeat_rate_p  (repeat_rate_p)
    ) u_key_repeat_right (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .tick_i  (tick_64hz_i),
        .key_i   (key_right),
        .set_o   (set_right)
    );

    phase_e                phase_q;
    cmd_e                  cmd_q;
    logic                  cmd_v_q;
    logic [1:0]            held_q;      // {rotate, start} level history
    logic [drop_w_lp-1:0]  drop_cnt_q;
    pend_t                 pend_q;

    pend_t                 pend_set;
    pend_t                 pend_d;
    pend_t                 mask;
    pend_t                 eligible;
    cmd_e                  issue_cmd;
    logic [drop_w_lp-1:0]  period_shift;
    logic [drop_w_lp-1:0]  drop_period;
    logic                  xfer;
    logic                  can_issue;
    logic                  to_play;
    logic                  to_over;
    logic                  drop_wrap;
    logic                  lr_clash;

    assign xfer      = cmd_v_q && cmd_ready_i;
    assign can_issue = !cmd_v_q || cmd_ready_i;
    assign to_play   = (phase_q != PH_PLAY) && xfer && (cmd_q == CMD_START);
    assign to_over   = (phase_q == PH_PLAY) && lose_i;
    assign lr_clash  = pend_q.left && pend_q.right;

    // Period halves per level; a level deep enough to shift everything out still drops every tick.
    assign period_shift = drop_w_lp'(drop_period_p) >> level_i;
    assign drop_period  = (period_shift == '0) ? drop_one_lp : period_shift;
    assign drop_wrap    = tick_64hz_i && (phase_q == PH_PLAY) &&
                          (drop_cnt_q >= drop_period - drop_one_lp);

    assign pend_set = '{
        start:  key_start && !held_q[0],
        rotate: key_rotate && !held_q[1],
        left:   set_left,
        right:  set_right,
        drop:   drop_wrap
    };

    always_comb begin
        // NOTE: every signal written here is assigned up front so no path can infer a latch.
        mask      = to_play ? phase_mask(PH_PLAY) : phase_mask(phase_q);
        if (to_over) mask = '0;
        eligible  = pend_q & mask;
        if (lr_clash) begin
            eligible.left  = 1'b0;
            eligible.right = 1'b0;
        end
        issue_cmd = can_issue ? pick_cmd(eligible) : CMD_NONE;
        pend_d    = pend_q & ~cmd_to_pend(issue_cmd);
        if (lr_clash) begin
            pend_d.left  = 1'b0;
            pend_d.right = 1'b0;
        end
        // Fresh requests win over this cycle's clears; ineligible ones are discarded.
        pend_d    = (pend_d | pend_set) & mask;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q    <= PH_IDLE;
            cmd_q      <= CMD_NONE;
            cmd_v_q    <= 1'b0;
            held_q     <= '0;
            drop_cnt_q <= '0;
            pend_q     <= '0;
        end else begin
            held_q <= {key_rotate, key_start};
            pend_q <= pend_d;

            if (can_issue) begin
                cmd_q   <= issue_cmd;
                cmd_v_q <= (issue_cmd != CMD_NONE);
            end

            if (drop_wrap) begin
                drop_cnt_q <= '0;
            end else if (tick_64hz_i && (phase_q == PH_PLAY)) begin
                drop_cnt_q <= drop_cnt_q + drop_one_lp;
            end

            case (phase_q)
                PH_IDLE, PH_OVER: begin
                    if (to_play) begin
                        phase_q    <= PH_PLAY;
                        drop_cnt_q <= '0;
                    end
                end
                PH_PLAY: begin
                    if (lose_i) phase_q <= PH_OVER;
                end
                default: phase_q <= PH_IDLE;
            endcase
        end
    end

    assign cmd_o   = cmd_q;
    assign cmd_v_o = cmd_v_q;
    assign phase_o = phase_q;

endmodule

// File: tb/tb_game_cmd_scheduler.sv
// Scoreboard bench: a request-level model pushes expected {command, tick} pairs as stimulus
// is driven; a monitor pops and compares them on every handshake transfer.
module tb_game_cmd_scheduler;
    import game_cmd_scheduler_pkg::*;

    localparam int DELAY  = 16;
    localparam int RATE   = 4;
    localparam int PERIOD = 32;
    localparam int LW     = 4;
    localparam int GAP    = 5;

    logic          clk_i       = 1'b0;
    logic          reset_i     = 1'b1;
    logic          tick_64hz_i = 1'b0;
    logic [3:0]    keys_i      = 4'b0000;
    logic [LW-1:0] level_i     = '0;
    logic          lose_i      = 1'b0;
    logic          cmd_ready_i = 1'b1;
    logic [2:0]    cmd_o;
    logic          cmd_v_o;
    logic [1:0]    phase_o;

    typedef struct {
        cmd_e cmd;
        int   tick;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tick_no  = 0;
    int   dcnt     = 0;
    int   hl       = 0;
    int   hr       = 0;
    int   n_cmd[6] = '{default: 0};
    bit   m_play   = 1'b0;

    always #5 clk_i = ~clk_i;

    game_cmd_scheduler #(
        .repeat_delay_p (DELAY),
        .repeat_rate_p  (RATE),
        .drop_period_p  (PERIOD),
        .level_w_p      (LW)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .tick_64hz_i (tick_64hz_i),
        .keys_i      (keys_i),
        .level_i     (level_i),
        .lose_i      (lose_i),
        .cmd_o       (cmd_o),
        .cmd_v_o     (cmd_v_o),
        .cmd_ready_i (cmd_ready_i),
        .phase_o     (phase_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void push(input cmd_e c);
        sb.push_back('{c, tick_no});
    endfunction

    function automatic bit rep_fire(input int n);
        return (n == DELAY) || (n > DELAY && ((n - DELAY) % RATE) == 0);
    endfunction

    function automatic int period_of(input int lvl);
        int p;
        p = PERIOD >> lvl;
        return (p == 0) ? 1 : p;
    endfunction

    // Transfer monitor: sampled mid-cycle, the transfer completes on the next rising edge.
    always @(negedge clk_i) begin
        if (!reset_i && cmd_v_o && cmd_ready_i) begin
            if (cmd_o < 3'd6) n_cmd[cmd_o]++;
            if (sb.size() == 0) begin
                check("unexpected_cmd", cmd_o, CMD_NONE);
            end else begin
                mon_e = sb.pop_front();
                check("cmd", cmd_o, mon_e.cmd);
                check("cmd_tick", tick_no, mon_e.tick);
                if (mon_e.cmd == CMD_START) begin
                    m_play = 1'b1;
                    dcnt   = 0;
                end
            end
        end
    end

    // Apply a key vector (and optionally a tick) for one cycle, predicting the resulting commands.
    task automatic drive(input logic [3:0] keys, input bit tk);
        bit f_start, f_rot, f_left, f_right, f_drop;
        @(posedge clk_i);
        #1;
        if (!keys[3]) hl = 0;
        if (!keys[2]) hr = 0;
        f_left  = keys[3] && !keys_i[3];
        f_right = keys[2] && !keys_i[2];
        f_rot   = keys[1] && !keys_i[1];
        f_start = keys[0] && !keys_i[0];
        f_drop  = 1'b0;
        if (tk) begin
            tick_no++;
            if (keys[3]) begin hl++; if (rep_fire(hl)) f_left = 1'b1; end
            if (keys[2]) begin hr++; if (rep_fire(hr)) f_right = 1'b1; end
            if (m_play) begin
                if (dcnt + 1 >= period_of(int'(level_i))) begin
                    dcnt   = 0;
                    f_drop = 1'b1;
                end else begin
                    dcnt++;
                end
            end
        end
        keys_i      = keys;
        tick_64hz_i = tk;
        if (m_play) begin
            if (f_rot) push(CMD_ROTATE);
            if (f_left && !f_right) push(CMD_LEFT);
            if (f_right && !f_left) push(CMD_RIGHT);
            if (f_drop) push(CMD_DROP);
        end else if (f_start) begin
            push(CMD_START);
        end
        @(posedge clk_i);
        #1;
        tick_64hz_i = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (GAP) @(posedge clk_i);
            drive(keys_i, 1'b1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk_i);
            n++;
        end
        check("drain_left", sb.size(), 0);
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   c0;
        cmd_e seq[3];
        seq = '{CMD_ROTATE, CMD_LEFT, CMD_DROP};

        // Reset with start held through it.
        keys_i = 4'b0001;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_cmd_v", cmd_v_o, 0);
        check("rst_cmd", cmd_o, CMD_NONE);
        check("rst_phase", phase_o, PH_IDLE);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        push(CMD_START);
        drain();
        check("phase_play", phase_o, PH_PLAY);
        drive(4'b0000, 1'b0);

        // Gravity at three levels.
        c0 = n_cmd[CMD_DROP];
        level_i = 4'd0;
        ticks(64);
        drain();
        level_i = 4'd3;
        ticks(12);
        drain();
        level_i = 4'd15;
        ticks(5);
        drain();
        check("drop_count", n_cmd[CMD_DROP] - c0, 10);

        // Hold left through delay and repeats, then release.
        level_i = 4'd0;
        c0 = n_cmd[CMD_LEFT];
        drive(4'b1000, 1'b0);
        ticks(38);
        drive(4'b0000, 1'b0);
        ticks(10);
        drain();
        check("left_count", n_cmd[CMD_LEFT] - c0, 7);

        // Rotate + left + drop pending together while ready is low.
        level_i = 4'd15;
        cmd_ready_i = 1'b0;
        drive(4'b1010, 1'b1);
        @(posedge clk_i);
        repeat (5) begin
            @(negedge clk_i);
            check("hold_v", cmd_v_o, 1);
            check("hold_cmd", cmd_o, CMD_ROTATE);
        end
        @(posedge clk_i);
        #1;
        cmd_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("b2b_v", cmd_v_o, 1);
            check("b2b_cmd", cmd_o, seq[i]);
        end
        drive(4'b0000, 1'b0);
        drain();

        // Left and right together cancel; start is ignored in PLAY.
        c0 = n_cmd[CMD_LEFT] + n_cmd[CMD_RIGHT];
        drive(4'b1100, 1'b0);
        ticks(3);
        drive(4'b0000, 1'b0);
        drain();
        check("lr_clash", n_cmd[CMD_LEFT] + n_cmd[CMD_RIGHT] - c0, 0);
        c0 = n_cmd[CMD_START];
        drive(4'b0001, 1'b0);
        repeat (10) @(posedge clk_i);
        drive(4'b0000, 1'b0);
        drain();
        check("start_in_play", n_cmd[CMD_START] - c0, 0);

        // Lose while a DROP is stalled.
        cmd_ready_i = 1'b0;
        drive(4'b0000, 1'b1);
        @(posedge clk_i);
        #1;
        lose_i = 1'b1;
        m_play = 1'b0;
        @(posedge clk_i);
        repeat (3) begin
            @(negedge clk_i);
            check("over_phase", phase_o, PH_OVER);
            check("over_v", cmd_v_o, 1);
            check("over_cmd", cmd_o, CMD_DROP);
        end
        @(posedge clk_i);
        #1;
        cmd_ready_i = 1'b1;
        drain();
        check("over_idle_v", cmd_v_o, 0);
        c0 = n_cmd[CMD_DROP] + n_cmd[CMD_LEFT];
        ticks(3);
        drive(4'b1000, 1'b0);
        drive(4'b0000, 1'b0);
        drain();
        check("over_quiet", n_cmd[CMD_DROP] + n_cmd[CMD_LEFT] - c0, 0);
        check("over_stay", phase_o, PH_OVER);

        // Restart from OVER; drop timer starts from zero.
        lose_i  = 1'b0;
        level_i = 4'd0;
        drive(4'b0001, 1'b0);
        drain();
        check("restart_phase", phase_o, PH_PLAY);
        drive(4'b0000, 1'b0);
        c0 = n_cmd[CMD_DROP];
        ticks(32);
        drain();
        check("restart_drop", n_cmd[CMD_DROP] - c0, 1);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
